// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage CPU.
//   DATA_W_DEF / REG_W_DEF : default operand and register-specifier widths
//   alu_op_e               : ALU operation class issued by decode
//   ex_ctrl_t              : control bits carried from ID into EX
//   EX_CTRL_NOP            : bubble value of ex_ctrl_t (writes nothing)
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        alu_op_e alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;
    localparam int       EX_CTRL_W   = $bits(ex_ctrl_t);

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register with hold and clear.
//   clk_i, rst_i : clock, asynchronous active-high reset (q -> 0)
//   en           : load d on the rising edge
//   clr          : load zero on the rising edge; takes priority over en
//   d / q        : field input / registered field
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures decoded operands, immediate, register specifiers and control bits
// from ID and presents them to EX one cycle later.
//   clk_i, rst_i          : clock, asynchronous active-high reset (all outputs -> 0)
//   stall_i               : hold every stored field
//   flush_i               : load a bubble (all fields 0); wins over stall_i
//   valid_i / valid_o     : real instruction in ID / in EX
//   data1/data2/imm       : operands and sign-extended immediate
//   rs/rt/rd              : register specifiers (feed the forwarding unit)
//   reg_write..alu_op     : EX/MEM/WB control bits
//   bubble_cnt_o          : saturating count of bubbles inserted since reset
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              alu_src_i,
    input  logic              reg_dst_i,
    input  logic [1:0]        alu_op_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_W-1:0]  rs_o,
    output logic [REG_W-1:0]  rt_o,
    output logic [REG_W-1:0]  rd_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              alu_src_o,
    output logic              reg_dst_o,
    output logic [1:0]        alu_op_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                load_en;
    ex_ctrl_t            ctrl_p0;
    ex_ctrl_t            ctrl_p1;
    logic [CNT_W-1:0]    bubble_cnt_p1;

    // ID side: bundle control bits; a stall simply withholds the load.
    assign load_en = ~stall_i;

    always_comb begin
        ctrl_p0            = EX_CTRL_NOP;
        ctrl_p0.reg_write  = reg_write_i;
        ctrl_p0.mem_to_reg = mem_to_reg_i;
        ctrl_p0.mem_read   = mem_read_i;
        ctrl_p0.mem_write  = mem_write_i;
        ctrl_p0.alu_src    = alu_src_i;
        ctrl_p0.reg_dst    = reg_dst_i;
        ctrl_p0.alu_op     = alu_op_e'(alu_op_i);
    end

    // ID -> EX boundary: one register per field group, flush clears over stall.
    pipe_field_reg #(.W(3 * DATA_W)) u_operands (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (load_en),
        .clr   (flush_i),
        .d     ({data1_i, data2_i, imm_i}),
        .q     ({data1_o, data2_o, imm_o})
    );

    pipe_field_reg #(.W(3 * REG_W)) u_specifiers (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (load_en),
        .clr   (flush_i),
        .d     ({rs_i, rt_i, rd_i}),
        .q     ({rs_o, rt_o, rd_o})
    );

    pipe_field_reg #(.W(EX_CTRL_W)) u_control (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (load_en),
        .clr   (flush_i),
        .d     (ctrl_p0),
        .q     (ctrl_p1)
    );

    pipe_field_reg #(.W(1)) u_valid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (load_en),
        .clr   (flush_i),
        .d     (valid_i),
        .q     (valid_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_p1 <= '0;
        end else if (flush_i) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    // EX side: unbundle registered control.
    assign reg_write_o  = ctrl_p1.reg_write;
    assign mem_to_reg_o = ctrl_p1.mem_to_reg;
    assign mem_read_o   = ctrl_p1.mem_read;
    assign mem_write_o  = ctrl_p1.mem_write;
    assign alu_src_o    = ctrl_p1.alu_src;
    assign reg_dst_o    = ctrl_p1.reg_dst;
    assign alu_op_o     = ctrl_p1.alu_op;
    assign bubble_cnt_o = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
        logic        mr;
        logic        mw;
        logic        as;
        logic        rdst;
        logic [1:0]  op;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0, flush = 1'b0, valid = 1'b0;
    logic [31:0] data1 = '0, data2 = '0, imm = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic rw = 1'b0, mtr = 1'b0, mr = 1'b0, mw = 1'b0, as = 1'b0, rdst = 1'b0;
    logic [1:0]  op = '0;

    // main DUT outputs
    logic        valid_o;
    logic [31:0] data1_o, data2_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        rw_o, mtr_o, mr_o, mw_o, as_o, rdst_o;
    logic [1:0]  op_o;
    logic [15:0] cnt_o;

    // narrow-counter DUT outputs
    logic        s_valid_o;
    logic [31:0] s_data1_o, s_data2_o, s_imm_o;
    logic [4:0]  s_rs_o, s_rt_o, s_rd_o;
    logic        s_rw_o, s_mtr_o, s_mr_o, s_mw_o, s_as_o, s_rdst_o;
    logic [1:0]  s_op_o;
    logic [1:0]  s_cnt_o;

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .data1_i(data1), .data2_i(data2), .imm_i(imm),
        .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .reg_write_i(rw), .mem_to_reg_i(mtr), .mem_read_i(mr), .mem_write_i(mw),
        .alu_src_i(as), .reg_dst_i(rdst), .alu_op_i(op),
        .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o), .imm_o(imm_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .reg_write_o(rw_o), .mem_to_reg_o(mtr_o), .mem_read_o(mr_o), .mem_write_o(mw_o),
        .alu_src_o(as_o), .reg_dst_o(rdst_o), .alu_op_o(op_o), .bubble_cnt_o(cnt_o)
    );

    id_ex_reg #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .data1_i(data1), .data2_i(data2), .imm_i(imm),
        .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .reg_write_i(rw), .mem_to_reg_i(mtr), .mem_read_i(mr), .mem_write_i(mw),
        .alu_src_i(as), .reg_dst_i(rdst), .alu_op_i(op),
        .valid_o(s_valid_o), .data1_o(s_data1_o), .data2_o(s_data2_o), .imm_o(s_imm_o),
        .rs_o(s_rs_o), .rt_o(s_rt_o), .rd_o(s_rd_o),
        .reg_write_o(s_rw_o), .mem_to_reg_o(s_mtr_o), .mem_read_o(s_mr_o), .mem_write_o(s_mw_o),
        .alu_src_o(s_as_o), .reg_dst_o(s_rdst_o), .alu_op_o(s_op_o), .bubble_cnt_o(s_cnt_o)
    );

    st_t dut_st, sat_st, in_st;
    assign dut_st = {valid_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o,
                     rw_o, mtr_o, mr_o, mw_o, as_o, rdst_o, op_o};
    assign sat_st = {s_valid_o, s_data1_o, s_data2_o, s_imm_o, s_rs_o, s_rt_o, s_rd_o,
                     s_rw_o, s_mtr_o, s_mr_o, s_mw_o, s_as_o, s_rdst_o, s_op_o};
    assign in_st  = {valid, data1, data2, imm, rs, rt, rd, rw, mtr, mr, mw, as, rdst, op};

    // Reference model: one action per edge, flush > stall > load; counters saturate.
    st_t m   = '0;
    int  mcnt  = 0;
    int  mcnt2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m     <= '0;
            mcnt  <= 0;
            mcnt2 <= 0;
        end else if (flush) begin
            m     <= '0;
            mcnt  <= (mcnt  < 65535) ? mcnt  + 1 : 65535;
            mcnt2 <= (mcnt2 < 3)     ? mcnt2 + 1 : 3;
        end else if (!stall) begin
            m <= in_st;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("state", dut_st, m);
            chk("state_sat", sat_st, m);
            chk("bubble_cnt", 128'(cnt_o), 128'(mcnt));
            chk("bubble_cnt_sat", 128'(s_cnt_o), 128'(mcnt2));
        end
    end

    task automatic cyc(input logic fl, input logic st);
        flush = fl;
        stall = st;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", 128'(valid_o), 128'(0));
        chk("reset_cnt", 128'(cnt_o), 128'(0));
        rst = 1'b0;

        // Load
        valid = 1'b1; data1 = 32'hDEAD_BEEF; rs = 5'd5; rw = 1'b1; op = 2'b10;
        cyc(1'b0, 1'b0);
        chk("load_data1", 128'(data1_o), 128'h DEAD_BEEF);
        chk("load_rs", 128'(rs_o), 128'd5);
        chk("load_rw", 128'(rw_o), 128'd1);
        chk("load_op", 128'(op_o), 128'd2);
        chk("load_valid", 128'(valid_o), 128'd1);

        // Stall three edges while the input changes
        data1 = 32'h1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1);
            chk("stall_hold", 128'(data1_o), 128'h DEAD_BEEF);
        end
        cyc(1'b0, 1'b0);
        chk("stall_release", 128'(data1_o), 128'h1);

        // Flush two edges with valid instruction presented
        for (int i = 1; i <= 2; i++) begin
            cyc(1'b1, 1'b0);
            chk("flush_valid", 128'(valid_o), 128'd0);
            chk("flush_rw", 128'(rw_o), 128'd0);
            chk("flush_data1", 128'(data1_o), 128'd0);
            chk("flush_cnt", 128'(cnt_o), 128'(i));
        end

        // Stall and flush together
        data1 = 32'h1234_5678;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        chk("stflush_valid", 128'(valid_o), 128'd0);
        chk("stflush_cnt", 128'(cnt_o), 128'd3);

        // Asynchronous reset mid-stall with non-zero outputs
        cyc(1'b0, 1'b0);
        chk("pre_rst_data1", 128'(data1_o), 128'h1234_5678);
        chk("pre_rst_cnt", 128'(cnt_o), 128'd3);
        stall = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data1", 128'(data1_o), 128'd0);
        chk("async_rst_valid", 128'(valid_o), 128'd0);
        chk("async_rst_cnt", 128'(cnt_o), 128'd0);
        chk("async_rst_cnt_sat", 128'(s_cnt_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b1);

        // Saturation of the 2-bit counter
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0);
            chk("sat_cnt2", 128'(s_cnt_o), 128'((i < 3) ? i : 3));
        end
        chk("sat_cnt16", 128'(cnt_o), 128'd5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            valid = 1'($urandom);
            data1 = $urandom; data2 = $urandom; imm = $urandom;
            rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            {rw, mtr, mr, mw, as, rdst} = 6'($urandom);
            op = 2'($urandom);
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
